// File: rtl/alu_pkg.sv
// Shared ALU types: operation encoding, the per-byte ALU request struct,
// and the sequencer state enum.
package alu_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        ALU_AND = 2'b00,
        ALU_OR  = 2'b01,
        ALU_ADD = 2'b10,
        ALU_SUB = 2'b11
    } ALU_Operation;

    typedef struct packed {
        logic [BYTE_W-1:0] operand1;
        logic [BYTE_W-1:0] operand2;
        logic              operand3;
        ALU_Operation      operation;
    } ALU_IO;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } seq_state_t;

    // Only ADD/SUB propagate a carry between bytes.
    function automatic logic is_arith(input ALU_Operation op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu_byte_sequencer_if.sv
// Request/response handshake bundle between a command source and the
// multi-byte ALU sequencer.
interface alu_byte_sequencer_if
    import alu_pkg::*;
#(
    parameter int unsigned NBYTES = 4
) ();

    localparam int unsigned W = BYTE_W * NBYTES;

    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    ALU_Operation req_op;
    logic         req_cin;

    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_result;
    logic         rsp_cout;

    modport master (
        output req_valid, req_a, req_b, req_op, req_cin, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_cout
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, req_cin, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_cout
    );

endinterface

// File: rtl/alu_byte_sequencer.sv
// Drives an external 8-bit ALU one byte per cycle (LSB first), chaining carry
// through operand3, and returns the assembled wide result.
module alu_byte_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned NBYTES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    alu_byte_sequencer_if.slave     bus,
    output ALU_IO                   alu_req,
    input  logic [BYTE_W-1:0]       alu_result,
    input  logic                    alu_cout
);

    localparam int unsigned W     = BYTE_W * NBYTES;
    localparam int unsigned IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int unsigned SEL_W = IDX_W + 3;

    seq_state_t     r_state;
    logic [IDX_W-1:0] r_idx;
    logic           r_carry;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    ALU_Operation   r_op;
    logic [W-1:0]   r_result;
    logic           r_cout;

    logic [SEL_W-1:0] w_lsb;
    logic             w_last;

    assign w_lsb  = {r_idx, 3'b000};
    assign w_last = (r_idx == IDX_W'(NBYTES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= ALU_AND;
            r_result <= '0;
            r_cout   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_a     <= bus.req_a;
                        r_b     <= bus.req_b;
                        r_op    <= bus.req_op;
                        r_carry <= is_arith(bus.req_op) & bus.req_cin;
                        r_idx   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_result[w_lsb +: BYTE_W] <= alu_result;
                    r_carry <= is_arith(r_op) & alu_cout;
                    if (w_last) begin
                        r_cout  <= is_arith(r_op) & alu_cout;
                        r_idx   <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                S_DONE: begin
                    if (bus.rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ALU request is idle (zero operands, AND) outside RUN.
    always_comb begin
        alu_req           = '0;
        alu_req.operation = ALU_AND;
        if (r_state == S_RUN) begin
            alu_req.operand1  = r_a[w_lsb +: BYTE_W];
            alu_req.operand2  = r_b[w_lsb +: BYTE_W];
            alu_req.operand3  = r_carry;
            alu_req.operation = r_op;
        end
    end

    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.rsp_valid  = (r_state == S_DONE);
    assign bus.rsp_result = r_result;
    assign bus.rsp_cout   = r_cout;

endmodule

// File: tb/tb_alu_byte_sequencer.sv
// Bench for alu_byte_sequencer with a behavioural 8-bit ALU and a wide-word
// reference model.
module tb_alu_byte_sequencer;
    import alu_pkg::*;

    localparam int unsigned NB = 4;
    localparam int unsigned W  = 8 * NB;

    logic       clk;
    logic       rst;
    ALU_IO      alu_req;
    logic [7:0] alu_result;
    logic       alu_cout;

    alu_byte_sequencer_if #(.NBYTES(NB)) bus ();

    alu_byte_sequencer #(.NBYTES(NB)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .alu_req    (alu_req),
        .alu_result (alu_result),
        .alu_cout   (alu_cout)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int acc_q[$];
    logic [W:0] rsp_q[$];
    logic o3_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (!rst && bus.req_valid && bus.req_ready) acc_q.push_back(cyc);
        if (!rst && bus.rsp_valid && bus.rsp_ready) rsp_q.push_back({bus.rsp_cout, bus.rsp_result});
    end

    // Behavioural 8-bit ALU standing in for Alu_8bit at the parent level.
    logic [7:0] alu_nb;
    logic [8:0] alu_s;
    always_comb begin
        alu_nb = ~alu_req.operand2;
        alu_s  = '0;
        case (alu_req.operation)
            ALU_AND: alu_s = {1'b0, alu_req.operand1 & alu_req.operand2};
            ALU_OR:  alu_s = {1'b0, alu_req.operand1 | alu_req.operand2};
            ALU_ADD: alu_s = {1'b0, alu_req.operand1} + {1'b0, alu_req.operand2} + {8'b0, alu_req.operand3};
            ALU_SUB: alu_s = {1'b0, alu_req.operand1} + {1'b0, alu_nb} + {8'b0, alu_req.operand3};
            default: alu_s = '0;
        endcase
    end
    assign alu_result = alu_s[7:0];
    assign alu_cout   = alu_s[8];

    // Whole-word reference: plain wide arithmetic, no byte slicing.
    function automatic void ref_op(input ALU_Operation op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, output logic [W-1:0] res, output logic co);
        logic [W:0]   s;
        logic [W-1:0] nb;
        nb = ~b;
        s  = '0;
        case (op)
            ALU_AND: s = {1'b0, a & b};
            ALU_OR:  s = {1'b0, a | b};
            ALU_ADD: s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            ALU_SUB: s = {1'b0, a} + {1'b0, nb} + {{W{1'b0}}, cin};
            default: s = '0;
        endcase
        res = s[W-1:0];
        co  = s[W];
    endfunction

    task automatic send_req(input ALU_Operation op, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        int n0;
        int budget;
        n0 = acc_q.size();
        budget = 0;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_cin   = cin;
        while (acc_q.size() == n0 && budget < 40) begin
            @(posedge clk); #1;
            budget++;
        end
        bus.req_valid = 1'b0;
        if (acc_q.size() == n0) begin
            n_tests++; n_fail++;
            $display("FAIL accept_timeout: request not accepted within %0d cycles", budget);
        end
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        o3_q.delete();
        while (!bus.rsp_valid && lat < 40) begin
            o3_q.push_back(alu_req.operand3);
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_rsp();
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_tests++;
        if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
        n_tests++;
        if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        n_tests++;
        if (bus.rsp_result !== '0) begin n_fail++; $display("FAIL reset_rsp_result: got %h want 0", bus.rsp_result); end
        n_tests++;
        if (bus.rsp_cout !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_cout: got %b want 0", bus.rsp_cout); end
        n_tests++;
        if (alu_req !== ALU_IO'('0)) begin n_fail++; $display("FAIL reset_alu_req: got %h want 0", alu_req); end
        n_tests++;
        if (acc_q.size() != 0) begin n_fail++; $display("FAIL reset_no_accept: got %0d acceptances want 0", acc_q.size()); end
    endtask

    task automatic test_directed();
        ALU_Operation ops [6] = '{ALU_ADD, ALU_ADD, ALU_SUB, ALU_SUB, ALU_AND, ALU_OR};
        logic [W-1:0] av  [6] = '{32'h0000_00FF, 32'hFFFF_FFFF, 32'h0000_0100, 32'h0000_0000, 32'hF0F0_1234, 32'hF0F0_1234};
        logic [W-1:0] bv  [6] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0FF0_FFFF, 32'h0FF0_FFFF};
        logic         cv  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [W-1:0] er  [6] = '{32'h0000_0100, 32'h0000_0000, 32'h0000_00FF, 32'hFFFF_FFFF, 32'h00F0_1234, 32'hFFF0_FFFF};
        logic         ec  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic         o3_add [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        int lat;
        for (int i = 0; i < 6; i++) begin
            send_req(ops[i], av[i], bv[i], cv[i]);
            wait_rsp(lat);
            n_tests++;
            if (lat != NB) begin n_fail++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, NB); end
            n_tests++;
            if (bus.rsp_result !== er[i]) begin n_fail++; $display("FAIL dir%0d_result: got %h want %h", i, bus.rsp_result, er[i]); end
            n_tests++;
            if (bus.rsp_cout !== ec[i]) begin n_fail++; $display("FAIL dir%0d_cout: got %b want %b", i, bus.rsp_cout, ec[i]); end
            if (i == 0 || i >= 4) begin
                n_tests++;
                if (o3_q.size() != NB) begin
                    n_fail++; $display("FAIL dir%0d_o3_count: got %0d want %0d", i, o3_q.size(), NB);
                end else begin
                    for (int k = 0; k < int'(NB); k++) begin
                        n_tests++;
                        if (o3_q[k] !== ((i == 0) ? o3_add[k] : 1'b0)) begin
                            n_fail++; $display("FAIL dir%0d_operand3_byte%0d: got %b want %b", i, k, o3_q[k], (i == 0) ? o3_add[k] : 1'b0);
                        end
                    end
                end
            end
            release_rsp();
            n_tests++;
            if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL dir%0d_back_idle: req_ready got %b want 1", i, bus.req_ready); end
        end
    endtask

    task automatic test_random();
        ALU_Operation op;
        logic [W-1:0] a, b, res;
        logic cin, co;
        int lat;
        for (int i = 0; i < 24; i++) begin
            op  = ALU_Operation'($urandom_range(0, 3));
            a   = W'($urandom);
            b   = W'($urandom);
            cin = 1'($urandom_range(0, 1));
            ref_op(op, a, b, cin, res, co);
            send_req(op, a, b, cin);
            wait_rsp(lat);
            n_tests++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== res || bus.rsp_cout !== co) begin
                n_fail++;
                $display("FAIL rand%0d op=%0d a=%h b=%h cin=%b: got v=%b r=%h c=%b want v=1 r=%h c=%b",
                         i, op, a, b, cin, bus.rsp_valid, bus.rsp_result, bus.rsp_cout, res, co);
            end
            release_rsp();
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] res;
        logic co;
        int lat;
        int n0;
        ref_op(ALU_SUB, 32'h1234_5678, 32'h8765_4321, 1'b1, res, co);
        send_req(ALU_SUB, 32'h1234_5678, 32'h8765_4321, 1'b1);
        wait_rsp(lat);
        n0 = acc_q.size();
        for (int k = 0; k < 5; k++) begin
            bus.req_valid = (k == 2);
            bus.req_op    = ALU_ADD;
            bus.req_a     = 32'h1111_1111;
            bus.req_b     = 32'h2222_2222;
            n_tests++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== res || bus.rsp_cout !== co || bus.req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got v=%b r=%h c=%b rdy=%b want v=1 r=%h c=%b rdy=0",
                         k, bus.rsp_valid, bus.rsp_result, bus.rsp_cout, bus.req_ready, res, co);
            end
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        release_rsp();
        n_tests++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_release: got rdy=%b v=%b want rdy=1 v=0", bus.req_ready, bus.rsp_valid);
        end
        n_tests++;
        if (acc_q.size() != n0) begin n_fail++; $display("FAIL bp_ignored_req: got %0d acceptances want %0d", acc_q.size(), n0); end
        n_tests++;
        if (bus.rsp_result !== res) begin n_fail++; $display("FAIL bp_result_held: got %h want %h", bus.rsp_result, res); end
    endtask

    task automatic test_reset_midrun();
        logic [W-1:0] a;
        int lat;
        int n0;
        a = 32'hA5C3_5A3C;
        send_req(ALU_ADD, a, 32'h0102_0304, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_tests++;
        if (alu_req.operand1 !== a[23:16]) begin n_fail++; $display("FAIL mid_byte2_operand1: got %h want %h", alu_req.operand1, a[23:16]); end
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_result !== '0 || alu_req !== ALU_IO'('0)) begin
            n_fail++;
            $display("FAIL mid_reset: got rdy=%b v=%b r=%h alu=%h want rdy=1 v=0 r=0 alu=0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_result, alu_req);
        end
        n0 = acc_q.size();
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        rst = 1'b0;
        #1;
        n_tests++;
        if (acc_q.size() != n0 || bus.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL mid_no_accept_in_reset: got acc=%0d rdy=%b want acc=%0d rdy=1", acc_q.size(), bus.req_ready, n0);
        end
        @(posedge clk); #1;
        send_req(ALU_ADD, 32'd3, 32'd4, 1'b0);
        wait_rsp(lat);
        n_tests++;
        if (bus.rsp_result !== 32'h0000_0007 || bus.rsp_cout !== 1'b0) begin
            n_fail++; $display("FAIL mid_fresh_add: got r=%h c=%b want r=00000007 c=0", bus.rsp_result, bus.rsp_cout);
        end
        release_rsp();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] r0, r1;
        logic c0, c1;
        int na, nr, budget;
        ref_op(ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, r0, c0);
        ref_op(ALU_SUB, 32'h0000_0005, 32'h0000_0009, 1'b1, r1, c1);
        na = acc_q.size();
        nr = rsp_q.size();
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_op = ALU_ADD; bus.req_a = 32'h7FFF_FFFF; bus.req_b = 32'h0000_0001; bus.req_cin = 1'b0;
        budget = 0;
        while (acc_q.size() < na + 1 && budget < 40) begin @(posedge clk); #1; budget++; end
        bus.req_op = ALU_SUB; bus.req_a = 32'h0000_0005; bus.req_b = 32'h0000_0009; bus.req_cin = 1'b1;
        while (acc_q.size() < na + 2 && budget < 80) begin @(posedge clk); #1; budget++; end
        bus.req_valid = 1'b0;
        while (rsp_q.size() < nr + 2 && budget < 120) begin @(posedge clk); #1; budget++; end
        bus.rsp_ready = 1'b0;
        n_tests++;
        if (acc_q.size() < na + 2 || rsp_q.size() < nr + 2) begin
            n_fail++; $display("FAIL b2b_timeout: got acc=%0d rsp=%0d want acc=%0d rsp=%0d", acc_q.size() - na, rsp_q.size() - nr, 2, 2);
        end else begin
            n_tests++;
            if (acc_q[na + 1] - acc_q[na] != NB + 2) begin
                n_fail++; $display("FAIL b2b_spacing: got %0d want %0d", acc_q[na + 1] - acc_q[na], NB + 2);
            end
            n_tests++;
            if (rsp_q[nr] !== {c0, r0}) begin n_fail++; $display("FAIL b2b_rsp0: got %h want %h", rsp_q[nr], {c0, r0}); end
            n_tests++;
            if (rsp_q[nr + 1] !== {c1, r1}) begin n_fail++; $display("FAIL b2b_rsp1: got %h want %h", rsp_q[nr + 1], {c1, r1}); end
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = ALU_AND;
        bus.req_cin   = 1'b0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_directed();
        test_random();
        test_backpressure();
        test_reset_midrun();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_byte_sequencer.md
# alu_byte_sequencer

Multi-byte operation sequencer that drives the team's 8-bit ALU (Alu_8bit) through its ALU_IO struct interface. It accepts one wide request (NBYTES×8-bit operands plus an ALU_Operation) over a valid/ready handshake. It then issues one ALU_IO per cycle, least-significant byte first, chaining the ALU carry-out back into operand3, and returns the assembled wide result and final carry over a second valid/ready handshake. It sits between a command source and a single Alu_8bit instance at the parent level.

## Interface
- NBYTES, default 4: number of 8-bit slices per operation; legal range 1–16.
- clk  input  1: rising-edge clock.
- rst  input  1: asynchronous, active-high reset.
- req_valid  input  1: request present.
- req_ready  output  1: sequencer can accept a request; high only in IDLE.
- req_a  input  8*NBYTES: operand A.
- req_b  input  8*NBYTES: operand B.
- req_op  input  ALU_Operation: AND/OR/ADD/SUB.
- req_cin  input  1: carry into byte 0 for ADD/SUB; set to 1 for a plain subtract.
- alu_req  output  ALU_IO: struct driven to the ALU (operand1, operand2, operand3, operation).
- alu_result  input  8: ALU result for the byte currently issued (combinational from alu_req).
- alu_cout  input  1: ALU carry-out for the byte currently issued.
- rsp_valid  output  1: response present.
- rsp_ready  input  1: consumer accepts response.
- rsp_result  output  8*NBYTES: assembled result.
- rsp_cout  output  1: final carry. ADD: carry out. SUB: 1 means no borrow. AND/OR: always 0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: req_ready=1. On req_valid, capture req_a, req_b, req_op, byte_idx=0, carry=req_cin (ADD/SUB) or 0 (AND/OR). Go to RUN.
- RUN: alu_req.operand1=A[8*byte_idx +: 8], operand2=B[8*byte_idx +: 8], operand3=carry, operation=captured op.
  - Each edge: write result byte byte_idx ← alu_result. For ADD/SUB, carry ← alu_cout; for AND/OR, carry stays 0.
  - byte_idx increments each cycle. At byte_idx==NBYTES-1, go to DONE.
- DONE: rsp_valid=1, and rsp_result/rsp_cout are held stable. When rsp_valid && rsp_ready, return to IDLE.
- Outside RUN, alu_req drives all-zero operands, operand3=0, operation=ALU_AND.
- rsp_result updates only in RUN. Between responses it holds its previous value.
- SUB relies on the ALU computing A + ~B + Cin per bit. The sequencer never inverts operands itself.
- req_valid while not in IDLE is ignored; there is no queueing.
- Reset (any state, including mid-RUN): state=IDLE, byte_idx=0, carry=0, rsp_result=0, rsp_cout=0, rsp_valid=0. The in-flight operation is discarded. req_ready reads 1 once state is IDLE, but nothing is accepted while rst is high.

## Timing
- Acceptance edge T: req_valid && req_ready sampled high.
- Byte k is issued during cycle T+1+k and captured at the end of that cycle.
- rsp_valid rises after edge T+NBYTES, so latency is NBYTES cycles from acceptance to rsp_valid.
- Minimum spacing between acceptances is NBYTES+2 cycles: the RUN cycles, one DONE cycle with immediate rsp_ready, and one IDLE cycle.
- NBYTES=1: a single RUN cycle, then DONE.
- All outputs are registered or decoded from the state register. The ALU path (alu_req → alu_result → result register) is the only combinational loop through the parent, and it is one ALU delay per cycle.

## Structure
- Shared package alu_pkg holds ALU_Operation (ALU_AND=00, ALU_OR=01, ALU_ADD=10, ALU_SUB=11), the ALU_IO struct, and the state enum. Both Alu_8bit and this block import it.
- No sub-module. The byte-select mux, result byte write, and FSM are inline. The ALU is instantiated by the parent, not inside this block.

## Test plan
All scenarios use NBYTES=4, with a real Alu_8bit wired to alu_req/alu_result/alu_cout.
- ADD 0x000000FF + 0x00000001, cin=0 → result 0x00000100, cout=0. operand3 sequence over the 4 RUN cycles is 0,1,0,0. rsp_valid rises 4 cycles after acceptance.
- ADD 0xFFFFFFFF + 0x00000001, cin=0 → 0x00000000, cout=1. Then SUB 0x00000100 − 0x00000001, cin=1 → 0x000000FF, cout=1. Then SUB 0x00000000 − 0x00000001, cin=1 → 0xFFFFFFFF, cout=0.
- AND 0xF0F01234 & 0x0FF0FFFF → 0x00F01234, cout=0, with operand3=0 every cycle. OR with the same operands → 0xFFF0FFFF, cout=0.
- Backpressure: hold rsp_ready=0 for 5 cycles in DONE → rsp_valid, rsp_result, and rsp_cout are stable. req_ready=0 throughout, and a req_valid pulse is ignored. On rsp_ready=1 the handshake completes, IDLE follows next cycle, and req_ready=1.
- Assert rst while byte_idx=2 in RUN → on the same cycle, state=IDLE, rsp_valid=0, rsp_result=0, and alu_req is zeroed. After release, a fresh ADD 3+4 returns 0x00000007.
- Back-to-back: issue two requests with rsp_ready tied high → second acceptance occurs exactly NBYTES+2 cycles after the first, and both results are correct.
